// File: rtl/fanout_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fanout_arbiter_pkg
// Shared definitions for the fanout arbiter:
//   state_t     - arbiter FSM states (IDLE / XFER)
//   BEAT_CNT_W  - width of the per-grant beat counter
//   idx_width() - index width for a requester count (minimum 1 bit)
// -----------------------------------------------------------------------------
package fanout_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   localparam int BEAT_CNT_W = 4;

   // clog2 that never returns 0, so a 2-requester arbiter still gets a 1-bit index
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fanout_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker: returns the first set request at or above
// i_ptr, wrapping modulo NUM_REQ.
// Ports:
//   i_req       - request vector
//   i_ptr       - search start index (always < NUM_REQ)
//   o_grant_oh  - one-hot grant (all zero when nothing requests)
//   o_grant_idx - binary index of the granted requester
//   o_any       - at least one request is set
// -----------------------------------------------------------------------------
module rr_select #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant_oh,
   output logic [IDX_W-1:0]   o_grant_idx,
   output logic               o_any
);

   // Rotate so that bit 0 of w_rot corresponds to requester i_ptr.
   logic [NUM_REQ-1:0] w_rot;

   assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);
   assign o_any = |i_req;

   always_comb begin : p_pick
      int sel;
      int idx;
      sel = 0;
      // Scan downward so the lowest rotated position wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) sel = k;
      end
      idx = int'(i_ptr) + sel;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      o_grant_idx = IDX_W'(idx);
      o_grant_oh  = o_any ? (NUM_REQ'(1) << o_grant_idx) : '0;
   end

endmodule

// File: rtl/fanout_arbiter.sv
// -----------------------------------------------------------------------------
// fanout_arbiter
// Round-robin arbiter funnelling NUM_REQ burst sources into one registered
// output channel. A grant stays locked to one requester until that requester
// sends a beat with req_last, or until MAX_BURST beats have been accepted.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; pick next requester round-robin from rr_ptr
// XFER  | grant locked; accept beats from the granted requester only
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_valid/data/last    - per-requester beat, payload, end-of-burst
//   req_ready              - per-requester beat accepted
//   out_valid/data/src/last- registered output beat, source index, last beat
//   out_ready              - downstream accepts the output beat
//   busy                   - FSM is in XFER
// -----------------------------------------------------------------------------
module fanout_arbiter
   import fanout_arbiter_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 8,
   parameter  int MAX_BURST = 4,
   localparam int SRC_W     = idx_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [SRC_W-1:0]          out_src,
   output logic                      out_last,
   input  logic                      out_ready,
   output logic                      busy
);

   localparam logic [BEAT_CNT_W-1:0] MAX_BURST_M1 = BEAT_CNT_W'(MAX_BURST - 1);
   localparam logic [SRC_W-1:0]      LAST_IDX     = SRC_W'(NUM_REQ - 1);

   state_t                  r_state;
   logic [SRC_W-1:0]        r_rr_ptr;
   logic [SRC_W-1:0]        r_grant;
   logic [NUM_REQ-1:0]      r_grant_oh;
   logic [BEAT_CNT_W-1:0]   r_beat_cnt;
   logic                    r_out_valid;
   logic [DATA_W-1:0]       r_out_data;
   logic [SRC_W-1:0]        r_out_src;
   logic                    r_out_last;

   logic [NUM_REQ-1:0]      w_rr_oh;
   logic [SRC_W-1:0]        w_rr_idx;
   logic                    w_rr_any;
   logic                    w_xfer;
   logic                    w_out_free;
   logic [NUM_REQ-1:0]      w_req_ready;
   logic                    w_accept;
   logic                    w_beat_last;
   logic [SRC_W-1:0]        w_next_ptr;
   logic [DATA_W-1:0]       w_sel_data;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (SRC_W)
   ) u_rr_select (
      .i_req       (req_valid),
      .i_ptr       (r_rr_ptr),
      .o_grant_oh  (w_rr_oh),
      .o_grant_idx (w_rr_idx),
      .o_any       (w_rr_any)
   );

   assign w_xfer      = (r_state == ST_XFER);
   // Output register can take a new beat when empty or draining this cycle.
   assign w_out_free  = !r_out_valid || out_ready;
   assign w_req_ready = (w_xfer && w_out_free) ? r_grant_oh : '0;
   assign w_accept    = |(req_valid & w_req_ready);
   assign w_beat_last = (|(req_last & r_grant_oh)) || (r_beat_cnt == MAX_BURST_M1);
   assign w_next_ptr  = (r_grant == LAST_IDX) ? '0 : r_grant + SRC_W'(1);
   assign w_sel_data  = req_data[r_grant*DATA_W +: DATA_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_grant_oh  <= '0;
         r_beat_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_src   <= r_grant;
            r_out_last  <= w_beat_last;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         case (r_state)
            // Arbitration does not look at out_ready: a new grant may be
            // issued while the previous final beat is still stalled.
            ST_IDLE: begin
               if (w_rr_any) begin
                  r_grant    <= w_rr_idx;
                  r_grant_oh <= w_rr_oh;
                  r_beat_cnt <= '0;
                  r_state    <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (w_accept) begin
                  if (w_beat_last) begin
                     r_state    <= ST_IDLE;
                     r_rr_ptr   <= w_next_ptr;
                     r_beat_cnt <= '0;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = w_req_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_last  = r_out_last;
   assign busy      = w_xfer;

endmodule

// File: tb/tb_fanout_arbiter.sv
module tb_fanout_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b1;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic [1:0]                out_src;
   logic                      out_last;
   logic                      out_ready;
   logic                      busy;

   fanout_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          src;
      logic [7:0]  data;
      int          last;
   } beat_t;

   beat_t exp_q[$];
   int    obs_src[$];
   int    obs_last[$];
   int    n_cmp = 0;
   int    n_err = 0;

   // Reference model: who holds the grant, how many beats it has sent,
   // where the next search starts, and whether the output slot is occupied.
   int    m_in_burst;
   int    m_owner;
   int    m_beats;
   int    m_ptr;
   int    m_out_full;
   int    m_acc [NUM_REQ];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_seq(input string nm, input int es[$], input int act[$]);
      int n;
      chk({nm, "_len"}, 64'(act.size()), 64'(es.size()));
      n = (act.size() < es.size()) ? act.size() : es.size();
      for (int i = 0; i < n; i++) chk(nm, 64'(act[i]), 64'(es[i]));
   endtask

   task automatic model_reset();
      m_in_burst = 0;
      m_owner    = 0;
      m_beats    = 0;
      m_ptr      = 0;
      m_out_full = 0;
   endtask

   // Called after inputs are driven for the cycle, before the rising edge.
   task automatic model_step();
      logic [NUM_REQ-1:0] exp_rdy;
      beat_t b;
      int    found;
      int    o;
      exp_rdy = (m_in_burst != 0 && (m_out_full == 0 || out_ready)) ? NUM_REQ'(1 << m_owner) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(m_in_burst));
      if (m_in_burst == 0) begin
         if (out_ready) m_out_full = 0;
         found = 0;
         for (int k = 0; k < NUM_REQ; k++) begin
            o = (m_ptr + k) % NUM_REQ;
            if (found == 0 && req_valid[o]) begin
               found      = 1;
               m_owner    = o;
               m_in_burst = 1;
               m_beats    = 0;
            end
         end
      end else if (req_valid[m_owner] && (m_out_full == 0 || out_ready)) begin
         m_beats++;
         m_acc[m_owner]++;
         b.src  = m_owner;
         b.data = req_data[m_owner*DATA_W +: DATA_W];
         b.last = (req_last[m_owner] || m_beats == MAX_BURST) ? 1 : 0;
         exp_q.push_back(b);
         m_out_full = 1;
         if (b.last != 0) begin
            m_in_burst = 0;
            m_ptr      = (m_owner + 1) % NUM_REQ;
         end
      end else if (out_ready) begin
         m_out_full = 0;
      end
   endtask

   task automatic drive(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ-1:0] l, input logic ordy);
      req_valid = v;
      req_last  = l;
      out_ready = ordy;
      req_data  = $urandom;
   endtask

   task automatic tick();
      #1;
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(4'h0, 4'h0, 1'b0);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_src", 64'(out_src), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      model_reset();
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: pops the scoreboard whenever a beat leaves the output register.
   initial begin : mon
      beat_t b;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat: got src %0d data %0d, expected no beat at %0t",
                        out_src, out_data, $time);
            end else begin
               b = exp_q.pop_front();
               chk("out_src", 64'(out_src), 64'(b.src));
               chk("out_data", 64'(out_data), 64'(b.data));
               chk("out_last", 64'(out_last), 64'(b.last));
            end
            obs_src.push_back(int'(out_src));
            obs_last.push_back(int'(out_last));
         end
      end
   end

   initial begin : stim
      int base;
      int g;
      int es[$];
      int el[$];
      logic [NUM_REQ-1:0] v_pat [8];
      logic [NUM_REQ-1:0] l_pat [8];

      for (int i = 0; i < NUM_REQ; i++) m_acc[i] = 0;
      model_reset();
      drive(4'h0, 4'h0, 1'b0);
      #3;
      do_reset();

      // All requesters, single-beat bursts: strict rotation 0,1,2,3,0.
      obs_src.delete(); obs_last.delete();
      repeat (10) begin drive(4'hF, 4'hF, 1'b1); tick(); end
      repeat (3) begin drive(4'h0, 4'h0, 1'b1); tick(); end
      es = '{0, 1, 2, 3, 0};
      chk_seq("rr_order", es, obs_src);

      // Requester 2 never marks last: burst cut at MAX_BURST, then re-grant.
      obs_src.delete(); obs_last.delete();
      base = m_acc[2];
      g = 0;
      while (m_acc[2] - base < 6 && g < 40) begin drive(4'b0100, 4'b0000, 1'b1); tick(); g++; end
      while (m_in_burst != 0 && g < 60) begin drive(4'b0100, 4'b0100, 1'b1); tick(); g++; end
      chk("maxburst_timeout", 64'(g < 60), 64'd1);
      repeat (3) begin drive(4'h0, 4'h0, 1'b1); tick(); end
      es = '{2, 2, 2, 2, 2, 2, 2};
      el = '{0, 0, 0, 1, 0, 0, 1};
      chk_seq("maxburst_src", es, obs_src);
      chk_seq("maxburst_last", el, obs_last);

      // Requester 1, 3-beat burst, downstream stalls 5 cycles after first beat.
      obs_src.delete(); obs_last.delete();
      base = m_acc[1];
      g = 0;
      while ((m_acc[1] - base < 3 || exp_q.size() > 0) && g < 40) begin
         drive((m_acc[1] - base < 3) ? 4'b0010 : 4'b0000,
               (m_acc[1] - base == 2) ? 4'b0010 : 4'b0000,
               (g >= 2 && g < 7) ? 1'b0 : 1'b1);
         tick();
         g++;
      end
      chk("stall_timeout", 64'(g < 40), 64'd1);
      es = '{1, 1, 1};
      el = '{0, 0, 1};
      chk_seq("stall_src", es, obs_src);
      chk_seq("stall_last", el, obs_last);

      // Requester 0 drops valid mid-burst; requester 3 must wait.
      do_reset();
      obs_src.delete(); obs_last.delete();
      v_pat = '{4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1000, 4'b1000};
      l_pat = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b1000};
      for (int i = 0; i < 8; i++) begin drive(v_pat[i], l_pat[i], 1'b1); tick(); end
      repeat (3) begin drive(4'h0, 4'h0, 1'b1); tick(); end
      es = '{0, 0, 3};
      chk_seq("lock_src", es, obs_src);

      // Reset pulse during beat 2 of a burst from requester 3.
      do_reset();
      obs_src.delete(); obs_last.delete();
      drive(4'b1000, 4'b0000, 1'b1); tick();
      drive(4'b1000, 4'b0000, 1'b1); tick();
      drive(4'b1000, 4'b0000, 1'b1);
      #1;
      model_step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(out_valid), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_req_ready", 64'(req_ready), 64'd0);
      model_reset();
      exp_q.delete();
      @(negedge clk);
      drive(4'h0, 4'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1001, 4'b1001, 1'b1); tick();
      drive(4'b1001, 4'b1001, 1'b1); tick();
      repeat (3) begin drive(4'h0, 4'h0, 1'b1); tick(); end
      es = '{3, 0};
      chk_seq("post_rst_src", es, obs_src);

      // Randomized traffic against the model.
      repeat (400) begin
         drive(4'($urandom), 4'($urandom & $urandom), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
         tick();
      end
      repeat (12) begin drive(4'hF, 4'hF, 1'b1); tick(); end
      repeat (4) begin drive(4'h0, 4'h0, 1'b1); tick(); end
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fanout_arbiter.md
FANOUT_ARBITER -- requirements
Module: fanout_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_REQ, 4, number of requesters sharing the output channel (2..8).
- DATA_W, 8, payload width in bits.
- MAX_BURST, 4, maximum beats per grant (1..15).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NUM_REQ, per-requester beat valid.
- req_data, input, NUM_REQ*DATA_W, per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last, input, NUM_REQ, per-requester end-of-burst marker.
- req_ready, output, NUM_REQ, per-requester beat accepted.
- out_valid, output, 1, shared output beat valid.
- out_data, output, DATA_W, shared output payload.
- out_src, output, clog2(NUM_REQ), index of the requester that sourced out_data.
- out_last, output, 1, last beat of the current grant.
- out_ready, input, 1, downstream accepts the beat.
- busy, output, 1, high while the FSM is in XFER.

Function
REQ-003 The FSM SHALL have two states: IDLE and XFER.
REQ-004 In IDLE, if any req_valid is high, the FSM SHALL grant the first requester with req_valid high, searching upward from rr_ptr modulo NUM_REQ, and move to XFER on the next edge.
REQ-005 In IDLE, every req_ready bit SHALL be 0.
REQ-006 In XFER, only req_ready[grant] SHALL be high, and only when the output register is empty or out_ready is high.
REQ-007 A beat SHALL be accepted when req_valid[grant] and req_ready[grant] are both high.
- On acceptance the output register loads data, src and last on the same edge.
- out_valid rises one cycle after acceptance.
REQ-008 The output register SHALL hold out_valid, out_data, out_src and out_last stable until out_ready is high.
- Full throughput: one beat per cycle while out_ready stays high.
REQ-009 A 4-bit beat counter SHALL count accepted beats within a grant.
- The burst ends on acceptance of a beat with req_last high, or of beat number MAX_BURST.
- out_last for that beat SHALL be 1.
- The FSM then returns to IDLE.
REQ-010 At burst end, rr_ptr SHALL become (grant+1) modulo NUM_REQ.
REQ-011 If req_valid[grant] drops mid-burst, the grant SHALL be held (locked) and no other requester shall be served.
REQ-012 Arbitration in IDLE SHALL ignore out_ready.
- A new grant may be issued while the final beat of the previous burst is still stalled in the output register.
REQ-013 busy SHALL equal (state==XFER).

Reset
REQ-014 While rst_n is low the block SHALL hold:
- state = IDLE, rr_ptr = 0, grant = 0, beat counter = 0;
- out_valid = 0, out_data = 0, out_src = 0, out_last = 0;
- req_ready = 0, busy = 0.
REQ-015 Reset assertion mid-burst SHALL immediately discard the in-flight beat and any held output.
REQ-016 After reset deasserts, the first arbitration SHALL start from requester 0.

Structure
REQ-017 A shared package fanout_arbiter_pkg SHALL hold:
- the FSM state enum;
- the constant BEAT_CNT_W = 4;
- the function computing clog2 for out_src width.
REQ-018 Round-robin selection SHALL be a separate combinational sub-module rr_select (inputs: request vector, pointer; outputs: one-hot grant, grant index, any).
- It is instantiated once.

Verification
REQ-019 Reset then all req_valid=1111, all req_last=1, out_ready=1 -> single-beat grants in order out_src=0,1,2,3,0; one output beat per two cycles.
REQ-020 req_valid[2]=1, req_last[2] never high, 6 beats offered, out_ready=1 -> 4 beats out_src=2; out_last on beat 4; re-grant required for beats 5-6.
REQ-021 Requester 1 streaming 3-beat burst with out_ready=0 for 5 cycles after the first beat -> out_data held stable, req_ready[1]=0 during stall, no beat lost or duplicated.
REQ-022 Requester 0 mid-burst drops req_valid for 3 cycles while req_valid[3]=1 -> req_ready[3] stays 0 until requester 0 sends req_last.
REQ-023 rst_n pulsed low during beat 2 of a burst from requester 3 -> out_valid=0 asynchronously; next grant goes to requester 0 when requesters 0 and 3 both request.
